keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles each column is driven before the scan advances.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20000, consecutive stable synchronised samples required for press and for release.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port row, input, 4, keypad rows (active-low, asynchronous).
REQ-006 SHALL have port col, output, 4, column drive (active-low, exactly one bit low).
REQ-007 SHALL have port digit, output, 4, BCD value of the last digit key; valid while load is high, held otherwise.
REQ-008 SHALL have ports load, bksp and clear, outputs, 1 each, one-cycle pulses feeding the BCD entry register.
REQ-009 SHALL have port op, output, 2, operator code, valid with op_valid.
REQ-010 SHALL have port op_valid, output, 1, one-cycle operator pulse.

Function
REQ-011 SHALL pass row through a 2-flop synchroniser before any use.
REQ-012 SHALL map row r/col c to keys as follows: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
REQ-013 SHALL use the following key actions: 0-9 give digit plus load; * gives bksp; # gives clear; A/B/C/D give op 0/1/2/3 plus op_valid.
REQ-014 SHALL implement FSM states SCAN, DEBOUNCE, EMIT and RELEASE.
REQ-015 SCAN SHALL hold each column SCAN_DIV cycles and sample on the last cycle; with all rows high it advances col 0->1->2->3->0 (wrap).
REQ-016 In SCAN, any row low SHALL latch col/row and enter DEBOUNCE; with multiple rows low, the lowest row index wins.
REQ-017 DEBOUNCE SHALL count consecutive cycles where the latched row is low; any high sample returns to SCAN at the next column with no output.
REQ-018 When the DEBOUNCE count reaches DEBOUNCE_CNT, the FSM SHALL enter EMIT.
REQ-019 EMIT SHALL last exactly one cycle, assert exactly one of load/bksp/clear/op_valid and then enter RELEASE.
REQ-020 RELEASE SHALL hold the column and require all rows high for DEBOUNCE_CNT consecutive cycles; any low sample restarts the count; completion enters SCAN at the next column.
REQ-021 Keys held or pressed during RELEASE SHALL never produce a second pulse (no auto-repeat).
REQ-022 At most one output pulse SHALL be high in any cycle.
REQ-023 digit SHALL update only in the EMIT cycle of a digit key.

Reset
REQ-024 While reset is high, the block SHALL hold FSM=SCAN, col=4'b1110, digit=4'b1111 (blank), op=0, all pulses 0, and counters and synchroniser cleared.
REQ-025 Reset asserted in any state, including mid-DEBOUNCE or mid-EMIT, SHALL abort with no pulse issued on that or the following cycle.

Configuration
REQ-026 With macro KEYPAD_OPKEYS_EN defined, keys A-D SHALL behave per REQ-013.
REQ-027 With KEYPAD_OPKEYS_EN undefined, A-D SHALL be debounced and waited for release but SHALL emit nothing, and op/op_valid SHALL be tied 0.

Structure
REQ-028 Package keypad_pkg SHALL hold the FSM state enum, the BLANK=4'hF constant, the op code constants and the key-to-action lookup table.
REQ-029 The 2-flop synchroniser SHALL be the single sub-module keypad_sync (4 bits wide).

Verification
REQ-030 (SCAN_DIV=4, DEBOUNCE_CNT=8 throughout) Press key 7 (r2,c0) stable -> one load pulse with digit=4'h7; no second pulse while held.
REQ-031 Bounce row low/high/low on alternating cycles for 20 cycles, then release -> no pulse, and the scan continues at the next column.
REQ-032 Press *, release, then press # -> exactly one bksp pulse, then exactly one clear pulse, separated by at least 8 cycles of release.
REQ-033 Press 1 and 4 simultaneously (c0, r0 and r1) -> a single load with digit=4'h1.
REQ-034 Assert reset at DEBOUNCE count 5 -> col=4'b1110, digit=4'hF, and no pulse occurs.
REQ-035 Press B -> op=1 with op_valid when KEYPAD_OPKEYS_EN is defined; all outputs silent when it is undefined.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, the blank
// digit code, operator codes and the row/column key action table.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] BLANK = 4'hF;

  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;
  localparam logic [1:0] OP_D = 2'd3;

  localparam logic [1:0] ACT_DIGIT = 2'd0;
  localparam logic [1:0] ACT_BKSP  = 2'd1;
  localparam logic [1:0] ACT_CLEAR = 2'd2;
  localparam logic [1:0] ACT_OP    = 2'd3;

  typedef struct packed {
    logic [1:0] act;
    logic [3:0] val;
  } key_t;

  // Indexed by {row, col}; entry 15 (r3,c3) is leftmost.
  localparam key_t [15:0] KEY_LUT = {
    {ACT_OP,    2'b00, OP_D}, {ACT_CLEAR, 4'h0}, {ACT_DIGIT, 4'h0}, {ACT_BKSP, 4'h0},
    {ACT_OP,    2'b00, OP_C}, {ACT_DIGIT, 4'h9}, {ACT_DIGIT, 4'h8}, {ACT_DIGIT, 4'h7},
    {ACT_OP,    2'b00, OP_B}, {ACT_DIGIT, 4'h6}, {ACT_DIGIT, 4'h5}, {ACT_DIGIT, 4'h4},
    {ACT_OP,    2'b00, OP_A}, {ACT_DIGIT, 4'h3}, {ACT_DIGIT, 4'h2}, {ACT_DIGIT, 4'h1}
  };

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous keypad row inputs.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_p0;
  logic [W-1:0] sync_p1;

  // Reset to the released (all-high) level so no phantom press is seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column scan, press/release debounce, one pulse per key.
// Optional macro KEYPAD_OPKEYS_EN enables operator outputs for keys A-D;
// without it those keys are debounced silently and op/op_valid stay 0.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] digit,
  output logic       load,
  output logic       bksp,
  output logic       clear,
  output logic [1:0] op,
  output logic       op_valid
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  logic [3:0]       row_s;
  state_e           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [3:0]       digit_q, digit_d;
  logic             load_c, bksp_c, clear_c;
  key_t             key;
`ifdef KEYPAD_OPKEYS_EN
  logic [1:0]       op_q, op_d;
  logic             op_fire;
`endif

  keypad_sync #(.W(4)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (row),
    .q     (row_s)
  );

  // Lowest-index low row wins when several rows are pressed together.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign key = KEY_LUT[{row_idx_q, col_idx_q}];

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      div_q     <= '0;
      deb_q     <= '0;
      digit_q   <= BLANK;
`ifdef KEYPAD_OPKEYS_EN
      op_q      <= OP_A;
`endif
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      digit_q   <= digit_d;
`ifdef KEYPAD_OPKEYS_EN
      op_q      <= op_d;
`endif
    end
  end

  // Next-state, counters and EMIT-cycle pulse decode.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    div_d     = div_q;
    deb_d     = deb_q;
    digit_d   = digit_q;
    load_c    = 1'b0;
    bksp_c    = 1'b0;
    clear_c   = 1'b0;
`ifdef KEYPAD_OPKEYS_EN
    op_d      = op_q;
    op_fire   = 1'b0;
`endif
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (row_s != 4'hF) begin
            row_idx_d = low_row(row_s);
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!row_s[row_idx_q]) begin
          if (deb_q == DEB_LAST) begin
            deb_d   = '0;
            state_d = EMIT;
            // Value registers change on entry so they are valid with the pulse.
            if (key.act == ACT_DIGIT) digit_d = key.val;
`ifdef KEYPAD_OPKEYS_EN
            if (key.act == ACT_OP) op_d = key.val[1:0];
`endif
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d     = '0;
          div_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end
      end
      EMIT: begin
        deb_d   = '0;
        state_d = RELEASE;
        // Gated by reset so an abort in this cycle emits nothing.
        if (!reset) begin
          case (key.act)
            ACT_DIGIT: load_c  = 1'b1;
            ACT_BKSP:  bksp_c  = 1'b1;
            ACT_CLEAR: clear_c = 1'b1;
            default: begin
`ifdef KEYPAD_OPKEYS_EN
              op_fire = 1'b1;
`endif
            end
          endcase
        end
      end
      RELEASE: begin
        if (row_s == 4'hF) begin
          if (deb_q == DEB_LAST) begin
            deb_d     = '0;
            div_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign col   = ~(4'b0001 << col_idx_q);
  assign digit = digit_q;
  assign load  = load_c;
  assign bksp  = bksp_c;
  assign clear = clear_c;
`ifdef KEYPAD_OPKEYS_EN
  assign op       = op_q;
  assign op_valid = op_fire;
`else
  assign op       = 2'b00;
  assign op_valid = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=8.
// Honours KEYPAD_OPKEYS_EN when choosing expectations for operator keys.
module tb_keypad_scan;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] digit;
  logic       load, bksp, clear, op_valid;
  logic [1:0] op;

  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int load_cnt = 0, bksp_cnt = 0, clear_cnt = 0, opv_cnt = 0, multi_cnt = 0;
  int bksp_cyc = 0, clear_cyc = 0;
  logic [3:0] load_digit = 4'h0;
  logic [1:0] op_last = 2'd0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .digit    (digit),
    .load     (load),
    .bksp     (bksp),
    .clear    (clear),
    .op       (op),
    .op_valid (op_valid)
  );

  always #5 clock = ~clock;

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Pulse monitor sampled on the falling edge.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if ((int'(load) + int'(bksp) + int'(clear) + int'(op_valid)) > 1) multi_cnt <= multi_cnt + 1;
    if (load)     begin load_cnt  <= load_cnt + 1;  load_digit <= digit; end
    if (bksp)     begin bksp_cnt  <= bksp_cnt + 1;  bksp_cyc   <= cyc;   end
    if (clear)    begin clear_cnt <= clear_cnt + 1; clear_cyc  <= cyc;   end
    if (op_valid) begin opv_cnt   <= opv_cnt + 1;   op_last    <= op;    end
  end

  function automatic int total_pulses();
    return load_cnt + bksp_cnt + clear_cnt + opv_cnt;
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_col_not(input logic [3:0] v, input int budget);
    for (int i = 0; i < budget && col == v; i++) tick();
  endtask

  task automatic wait_col_is(input logic [3:0] v, input int budget);
    for (int i = 0; i < budget && col != v; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    keys  = '0;
    repeat (3) tick();
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got=%b want=%b", col, 4'b1110); end
    checks++; if (digit !== 4'hF) begin errors++; $display("FAIL reset_digit got=%h want=%h", digit, 4'hF); end
    checks++; if (op !== 2'd0) begin errors++; $display("FAIL reset_op got=%0d want=0", op); end
    checks++; if ({load, bksp, clear, op_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses got=%b want=0000", {load, bksp, clear, op_valid}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_digit_press();
    int base;
    base = load_cnt;
    keys = 16'h0001 << 8;
    for (int i = 0; i < 200 && load_cnt == base; i++) tick();
    checks++; if (load_cnt !== base + 1) begin errors++; $display("FAIL key7_load got=%0d want=%0d", load_cnt - base, 1); end
    checks++; if (load_digit !== 4'h7) begin errors++; $display("FAIL key7_digit got=%h want=7", load_digit); end
    repeat (40) tick();
    checks++; if (load_cnt !== base + 1) begin errors++; $display("FAIL key7_repeat got=%0d want=%0d", load_cnt - base, 1); end
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL key7_hold_col got=%b want=1110", col); end
    keys = '0;
    wait_col_not(4'b1110, 40);
    checks++; if (col !== 4'b1101) begin errors++; $display("FAIL key7_next_col got=%b want=1101", col); end
  endtask

  task automatic test_bounce();
    int base;
    logic [3:0] cur;
    base = total_pulses();
    wait_col_is(4'b1101, 40);
    for (int i = 0; i < 20; i++) begin
      keys = (i % 2 == 0) ? (16'h0001 << 5) : 16'h0000;
      tick();
    end
    keys = '0;
    repeat (3) tick();
    cur = col;
    wait_col_not(cur, 40);
    checks++; if (col !== {cur[2:0], cur[3]}) begin
      errors++; $display("FAIL bounce_next_col got=%b want=%b", col, {cur[2:0], cur[3]}); end
    checks++; if (total_pulses() !== base) begin
      errors++; $display("FAIL bounce_pulses got=%0d want=0", total_pulses() - base); end
  endtask

  task automatic test_back_to_back();
    int b, c, l;
    b = bksp_cnt; c = clear_cnt; l = load_cnt;
    keys = 16'h0001 << 12;
    for (int i = 0; i < 200 && bksp_cnt == b; i++) tick();
    repeat (5) tick();
    keys = '0;
    wait_col_not(4'b1110, 40);
    keys = 16'h0001 << 14;
    for (int i = 0; i < 200 && clear_cnt == c; i++) tick();
    repeat (5) tick();
    keys = '0;
    wait_col_not(4'b1011, 40);
    checks++; if (bksp_cnt !== b + 1) begin errors++; $display("FAIL star_bksp got=%0d want=1", bksp_cnt - b); end
    checks++; if (clear_cnt !== c + 1) begin errors++; $display("FAIL hash_clear got=%0d want=1", clear_cnt - c); end
    checks++; if ((clear_cyc - bksp_cyc) <= 8) begin
      errors++; $display("FAIL b2b_gap got=%0d want>8", clear_cyc - bksp_cyc); end
    checks++; if (load_cnt !== l) begin errors++; $display("FAIL b2b_no_load got=%0d want=0", load_cnt - l); end
  endtask

  task automatic test_multi_row();
    int base;
    base = load_cnt;
    keys = (16'h0001 << 0) | (16'h0001 << 4);
    for (int i = 0; i < 200 && load_cnt == base; i++) tick();
    repeat (20) tick();
    checks++; if (load_cnt !== base + 1) begin errors++; $display("FAIL multi_load got=%0d want=1", load_cnt - base); end
    checks++; if (load_digit !== 4'h1) begin errors++; $display("FAIL multi_digit got=%h want=1", load_digit); end
    keys = '0;
    wait_col_not(4'b1110, 40);
  endtask

  task automatic test_reset_abort();
    int base;
    base = total_pulses();
    wait_col_not(4'b1110, 40);
    wait_col_is(4'b1110, 40);
    keys = 16'h0001 << 4;
    repeat (9) tick();
    reset = 1'b1;
    keys  = '0;
    tick();
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL abort_col got=%b want=1110", col); end
    checks++; if (digit !== 4'hF) begin errors++; $display("FAIL abort_digit got=%h want=F", digit); end
    repeat (2) tick();
    reset = 1'b0;
    repeat (40) tick();
    checks++; if (total_pulses() !== base) begin
      errors++; $display("FAIL abort_pulses got=%0d want=0", total_pulses() - base); end
  endtask

  task automatic test_opkey();
    int base, ob;
    base = total_pulses();
    ob   = opv_cnt;
    keys = 16'h0001 << 7;
`ifdef KEYPAD_OPKEYS_EN
    for (int i = 0; i < 200 && opv_cnt == ob; i++) tick();
    repeat (20) tick();
    checks++; if (opv_cnt !== ob + 1) begin errors++; $display("FAIL opb_valid got=%0d want=1", opv_cnt - ob); end
    checks++; if (op_last !== 2'd1) begin errors++; $display("FAIL opb_code got=%0d want=1", op_last); end
`else
    repeat (100) tick();
    checks++; if (total_pulses() !== base) begin
      errors++; $display("FAIL opb_silent got=%0d want=0", total_pulses() - base); end
    checks++; if (op !== 2'd0) begin errors++; $display("FAIL opb_op_tied got=%0d want=0", op); end
`endif
    checks++; if (col !== 4'b0111) begin errors++; $display("FAIL opb_hold_col got=%b want=0111", col); end
    keys = '0;
    wait_col_not(4'b0111, 40);
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL opb_next_col got=%b want=1110", col); end
  endtask

  task automatic test_onehot();
    checks++; if (multi_cnt !== 0) begin errors++; $display("FAIL onehot_pulses got=%0d want=0", multi_cnt); end
  endtask

  initial begin
    test_reset();
    test_digit_press();
    test_bounce();
    test_back_to_back();
    test_multi_row();
    test_reset_abort();
    test_opkey();
    test_onehot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
